// File: rtl/drv_pkg.sv
// Shared types and constants for the gate drive stage: leg state encoding, default widths
// and the parameter-RAM addresses that feed dead time and OCD threshold.
package drv_pkg;

    localparam int unsigned DefDtBits  = 8;
    localparam int unsigned DefCurBits = 16;

    // Parameter RAM scan addresses; keep in step with the register defines.
    localparam logic [7:0] ADDR_DEADTIME = 8'h10;
    localparam logic [7:0] ADDR_OCD      = 8'h11;

    typedef enum logic [2:0] {
        StOff,
        StDtHi,
        StHi,
        StDtLo,
        StLo
    } leg_state_t;

endpackage

// File: rtl/deadtime_leg.sv
// One half-bridge leg: complementary gate FSM with a dead-time counter between
// high-side and low-side conduction.
module deadtime_leg
    import drv_pkg::*;
#(
    parameter int unsigned DT_BITS = DefDtBits
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               kill,
    input  logic               pwm,
    input  logic [DT_BITS-1:0] deadtime,
    output logic               gate_hi,
    output logic               gate_lo
);

    leg_state_t         state_q, state_d;
    logic [DT_BITS-1:0] cnt_q, cnt_d;
    logic               gate_hi_d, gate_lo_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StOff;
            cnt_q   <= '0;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gate_hi <= gate_hi_d;
            gate_lo <= gate_lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (kill) begin
            state_d = StOff;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StOff: begin
                    state_d = pwm ? StDtHi : StDtLo;
                    cnt_d   = deadtime;
                end
                // Neither gate conducts in a DT state, so a reversed command simply retargets
                // and keeps counting down.
                StDtHi, StDtLo: begin
                    if (cnt_q == '0) begin
                        state_d = pwm ? StHi : StLo;
                    end else begin
                        state_d = pwm ? StDtHi : StDtLo;
                        cnt_d   = cnt_q - 1'b1;
                    end
                end
                StHi: begin
                    if (!pwm) begin
                        state_d = StDtLo;
                        cnt_d   = deadtime;
                    end
                end
                StLo: begin
                    if (pwm) begin
                        state_d = StDtHi;
                        cnt_d   = deadtime;
                    end
                end
                default: begin
                    state_d = StOff;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        gate_hi_d = (state_d == StHi);
        gate_lo_d = (state_d == StLo);
    end

endmodule

// File: rtl/gate_deadtime_ocd.sv
// Complementary gate drive with per-leg dead time, plus a filtered, latched over-current
// trip that forces every leg off until cleared.
module gate_deadtime_ocd
    import drv_pkg::*;
#(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DT_BITS    = DefDtBits,
    parameter int unsigned CUR_BITS   = DefCurBits,
    parameter int unsigned OCD_FILTER = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CHANNELS-1:0] pwm_in,
    input  logic [DT_BITS-1:0]  deadtime,
    input  logic [CUR_BITS-1:0] ocd_thresh,
    input  logic [CUR_BITS-1:0] cur,
    input  logic                cur_val,
    input  logic                fault_clr,
    output logic [CHANNELS-1:0] gate_hi,
    output logic [CHANNELS-1:0] gate_lo,
    output logic                fault,
    output logic [7:0]          trip_cnt
);

    localparam logic [7:0] FilterMax = 8'(OCD_FILTER);

    logic [7:0] over_cnt_q, over_cnt_d;
    logic       fault_q, fault_d;
    logic [7:0] trip_cnt_q, trip_cnt_d;
    logic       trip;
    logic       kill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            over_cnt_q <= '0;
            fault_q    <= 1'b0;
            trip_cnt_q <= '0;
        end else begin
            over_cnt_q <= over_cnt_d;
            fault_q    <= fault_d;
            trip_cnt_q <= trip_cnt_d;
        end
    end

    always_comb begin
        over_cnt_d = over_cnt_q;
        if (cur_val) begin
            if (cur > ocd_thresh) begin
                if (over_cnt_q != FilterMax) begin
                    over_cnt_d = over_cnt_q + 8'd1;
                end
            end else begin
                over_cnt_d = '0;
            end
        end

        trip = (over_cnt_d == FilterMax);

        // Trip beats clear; clear only once the current has dropped back below threshold.
        fault_d = fault_q;
        if (trip) begin
            fault_d = 1'b1;
        end else if (fault_clr && (over_cnt_q == '0)) begin
            fault_d = 1'b0;
        end

        trip_cnt_d = trip_cnt_q;
        if (fault_d && !fault_q && (trip_cnt_q != 8'hff)) begin
            trip_cnt_d = trip_cnt_q + 8'd1;
        end

        kill = ~en | fault_d;
    end

    assign fault    = fault_q;
    assign trip_cnt = trip_cnt_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_leg
        deadtime_leg #(
            .DT_BITS(DT_BITS)
        ) u_leg (
            .clk     (clk),
            .rst     (rst),
            .kill    (kill),
            .pwm     (pwm_in[i]),
            .deadtime(deadtime),
            .gate_hi (gate_hi[i]),
            .gate_lo (gate_lo[i])
        );
    end

endmodule

// File: tb/tb_gate_deadtime_ocd.sv
// Directed vector table plus hand-written multi-cycle sequences for gate_deadtime_ocd.
module tb_gate_deadtime_ocd;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  pwm_in;
    logic [7:0]  deadtime;
    logic [15:0] ocd_thresh;
    logic [15:0] cur;
    logic        cur_val;
    logic        fault_clr;
    logic [1:0]  gate_hi;
    logic [1:0]  gate_lo;
    logic        fault;
    logic [7:0]  trip_cnt;

    int checks = 0;
    int errors = 0;
    bit run_inv = 1'b0;

    gate_deadtime_ocd #(
        .CHANNELS  (2),
        .DT_BITS   (8),
        .CUR_BITS  (16),
        .OCD_FILTER(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pwm_in    (pwm_in),
        .deadtime  (deadtime),
        .ocd_thresh(ocd_thresh),
        .cur       (cur),
        .cur_val   (cur_val),
        .fault_clr (fault_clr),
        .gate_hi   (gate_hi),
        .gate_lo   (gate_lo),
        .fault     (fault),
        .trip_cnt  (trip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  pwm;
        logic [7:0]  dt;
        logic [15:0] thr;
        logic [15:0] cur;
        logic        cv;
        logic        clr;
        logic [1:0]  e_hi;
        logic [1:0]  e_lo;
        logic        e_f;
        logic [7:0]  e_trip;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en_v, input logic [1:0] pwm_v, input logic [7:0] dt_v,
                       input logic [15:0] thr_v, input logic [15:0] cur_v, input logic cv_v,
                       input logic clr_v, input logic [1:0] hi_v, input logic [1:0] lo_v,
                       input logic f_v, input logic [7:0] trip_v);
        vec_t v;
        v.en = en_v; v.pwm = pwm_v; v.dt = dt_v; v.thr = thr_v; v.cur = cur_v;
        v.cv = cv_v; v.clr = clr_v; v.e_hi = hi_v; v.e_lo = lo_v; v.e_f = f_v;
        v.e_trip = trip_v;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shoot-through guard, sampled every falling edge outside reset.
    always @(negedge clk) begin
        if (run_inv && !rst) begin
            checks++;
            if ((gate_hi & gate_lo) != 2'b00) begin
                errors++;
                $display("FAIL shoot_through: hi %b lo %b expected no overlap", gate_hi, gate_lo);
            end
        end
    end

    initial begin
        int n;
        int lo_back;
        bit hi_seen;
        logic prev_hi;
        logic prev_lo;

        rst = 1'b1; en = 1'b0; pwm_in = 2'b00; deadtime = 8'd0; ocd_thresh = 16'd1000;
        cur = 16'd0; cur_val = 1'b0; fault_clr = 1'b0;

        //   en pwm    dt  thr       cur       cv clr  hi     lo     f  trip
        add(0, 2'b00, 2,  16'd1000, 16'd0,    0, 0,  2'b00, 2'b00, 0, 0);
        add(1, 2'b01, 2,  16'd1000, 16'd0,    0, 0,  2'b00, 2'b00, 0, 0);
        add(1, 2'b01, 2,  16'd1000, 16'd0,    0, 0,  2'b00, 2'b00, 0, 0);
        add(1, 2'b01, 2,  16'd1000, 16'd0,    0, 0,  2'b00, 2'b00, 0, 0);
        add(1, 2'b01, 2,  16'd1000, 16'd0,    0, 0,  2'b01, 2'b10, 0, 0);
        add(1, 2'b01, 2,  16'd1000, 16'd0,    0, 0,  2'b01, 2'b10, 0, 0);
        add(1, 2'b10, 2,  16'd1000, 16'd0,    0, 0,  2'b00, 2'b00, 0, 0);
        add(1, 2'b10, 5,  16'd1000, 16'd0,    0, 0,  2'b00, 2'b00, 0, 0);
        add(1, 2'b10, 5,  16'd1000, 16'd0,    0, 0,  2'b00, 2'b00, 0, 0);
        add(1, 2'b10, 5,  16'd1000, 16'd0,    0, 0,  2'b10, 2'b01, 0, 0);
        add(1, 2'b11, 0,  16'd1000, 16'd0,    0, 0,  2'b10, 2'b00, 0, 0);
        add(1, 2'b11, 0,  16'd1000, 16'd0,    0, 0,  2'b11, 2'b00, 0, 0);
        add(1, 2'b11, 0,  16'd1000, 16'd1001, 1, 0,  2'b11, 2'b00, 0, 0);
        add(1, 2'b11, 0,  16'd1000, 16'd1001, 0, 0,  2'b11, 2'b00, 0, 0);
        add(1, 2'b11, 0,  16'd1000, 16'd999,  1, 0,  2'b11, 2'b00, 0, 0);
        add(1, 2'b11, 0,  16'd1000, 16'd1001, 1, 0,  2'b11, 2'b00, 0, 0);
        add(1, 2'b11, 0,  16'd1000, 16'd1001, 1, 0,  2'b11, 2'b00, 0, 0);
        add(1, 2'b11, 0,  16'd1000, 16'd1001, 1, 0,  2'b11, 2'b00, 0, 0);
        add(1, 2'b11, 0,  16'd1000, 16'd1001, 1, 0,  2'b00, 2'b00, 1, 1);
        add(1, 2'b11, 0,  16'd1000, 16'd1001, 0, 1,  2'b00, 2'b00, 1, 1);
        add(1, 2'b11, 0,  16'd1000, 16'd1001, 1, 0,  2'b00, 2'b00, 1, 1);
        add(1, 2'b11, 0,  16'd1000, 16'd500,  1, 0,  2'b00, 2'b00, 1, 1);
        add(1, 2'b11, 3,  16'd1000, 16'd500,  0, 1,  2'b00, 2'b00, 0, 1);
        add(1, 2'b11, 3,  16'd1000, 16'd500,  0, 0,  2'b00, 2'b00, 0, 1);
        add(1, 2'b11, 3,  16'd1000, 16'd500,  0, 0,  2'b00, 2'b00, 0, 1);
        add(1, 2'b11, 3,  16'd1000, 16'd500,  0, 0,  2'b00, 2'b00, 0, 1);
        add(1, 2'b11, 3,  16'd1000, 16'd500,  0, 0,  2'b11, 2'b00, 0, 1);
        add(0, 2'b11, 3,  16'd1000, 16'd500,  0, 0,  2'b00, 2'b00, 0, 1);
        add(1, 2'b00, 0,  16'hffff, 16'hffff, 1, 0,  2'b00, 2'b00, 0, 1);
        for (int k = 0; k < 5; k++)
            add(1, 2'b00, 0, 16'hffff, 16'hffff, 1, 0, 2'b00, 2'b11, 0, 1);
        for (int k = 0; k < 3; k++)
            add(1, 2'b00, 0, 16'd1000, 16'd2000, 1, 0, 2'b00, 2'b11, 0, 1);
        add(1, 2'b00, 0,  16'd1000, 16'd2000, 1, 0,  2'b00, 2'b00, 1, 2);

        // Reset state
        tick();
        tick();
        chk("reset_hi", 32'(gate_hi), 32'h0);
        chk("reset_lo", 32'(gate_lo), 32'h0);
        chk("reset_fault", 32'(fault), 32'h0);
        chk("reset_trip", 32'(trip_cnt), 32'h0);
        rst = 1'b0;
        run_inv = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en; pwm_in = vecs[i].pwm; deadtime = vecs[i].dt;
            ocd_thresh = vecs[i].thr; cur = vecs[i].cur; cur_val = vecs[i].cv;
            fault_clr = vecs[i].clr;
            tick();
            chk($sformatf("row%0d_hi", i), 32'(gate_hi), 32'(vecs[i].e_hi));
            chk($sformatf("row%0d_lo", i), 32'(gate_lo), 32'(vecs[i].e_lo));
            chk($sformatf("row%0d_fault", i), 32'(fault), 32'(vecs[i].e_f));
            chk($sformatf("row%0d_trip", i), 32'(trip_cnt), 32'(vecs[i].e_trip));
        end

        // Clear the latched fault, settle both legs in LO.
        cur = 16'd500; cur_val = 1'b1; fault_clr = 1'b0;
        tick();
        cur_val = 1'b0; fault_clr = 1'b1; pwm_in = 2'b00; deadtime = 8'd0;
        tick();
        fault_clr = 1'b0;
        tick();
        chk("clr_fault", 32'(fault), 32'h0);
        chk("clr_lo", 32'(gate_lo), 32'h3);

        // deadtime=5: low side drops after one edge, high side after 7, 6 cycles both off.
        deadtime = 8'd5; pwm_in = 2'b01;
        tick();
        chk("dt5_lo_fall", 32'({gate_hi[0], gate_lo[0]}), 32'h0);
        n = 1;
        while (!gate_hi[0] && n < 20) begin
            tick();
            n++;
            if (!gate_hi[0]) chk("dt5_gap_lo", 32'(gate_lo[0]), 32'h0);
        end
        chk("dt5_rise_edge", 32'(n), 32'd7);

        // deadtime=10 with a command reversal three cycles into DT_HI.
        pwm_in = 2'b00; deadtime = 8'd10;
        for (int k = 0; k < 12; k++) tick();
        chk("dt10_start_lo", 32'(gate_lo[0]), 32'h1);
        pwm_in = 2'b01;
        hi_seen = 1'b0;
        lo_back = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 4) pwm_in = 2'b00;
            tick();
            if (gate_hi[0]) hi_seen = 1'b1;
            if (gate_lo[0] && lo_back == 0) lo_back = k;
        end
        chk("retarget_no_hi", 32'(hi_seen), 32'h0);
        chk("retarget_lo_back", 32'(lo_back), 32'd12);

        // deadtime=0, leg 1 toggled every cycle: no gate held on two cycles in a row.
        deadtime = 8'd0;
        prev_hi = gate_hi[1];
        prev_lo = gate_lo[1];
        for (int k = 1; k <= 20; k++) begin
            pwm_in[1] = k[0];
            tick();
            chk($sformatf("toggle%0d", k), 32'({prev_hi & gate_hi[1], prev_lo & gate_lo[1]}),
                32'h0);
            prev_hi = gate_hi[1];
            prev_lo = gate_lo[1];
        end

        // en drop while HI
        pwm_in = 2'b11;
        for (int k = 0; k < 3; k++) tick();
        chk("en_pre_hi", 32'(gate_hi), 32'h3);
        en = 1'b0;
        tick();
        chk("en_off_hi", 32'(gate_hi), 32'h0);
        chk("en_off_lo", 32'(gate_lo), 32'h0);

        // Async reset while HI, then mid-DT; restart must run the full dead time.
        en = 1'b1; deadtime = 8'd2;
        for (int k = 0; k < 4; k++) tick();
        chk("rst_pre_hi", 32'(gate_hi), 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_hi", 32'(gate_hi), 32'h0);
        chk("rst_async_trip", 32'(trip_cnt), 32'h0);
        tick();
        rst = 1'b0;
        deadtime = 8'd10;
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        #1;
        chk("rst_middt_hi", 32'(gate_hi | gate_lo), 32'h0);
        tick();
        rst = 1'b0;
        deadtime = 8'd2;
        for (int k = 0; k < 3; k++) tick();
        chk("restart_gap", 32'(gate_hi), 32'h0);
        tick();
        chk("restart_hi", 32'(gate_hi), 32'h3);

        run_inv = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
